// File: rtl/wb_stage_pipe_if.sv
// MEM->WB stage bundle: stage controls, MEM-stage entry, and writeback/bypass/retire results.
interface wb_stage_pipe_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
);
  logic              flushW;
  logic              bubbleW;
  logic              in_valid;
  logic [XLEN-1:0]   in_pc;
  logic [REG_AW-1:0] in_rd;
  logic [XLEN-1:0]   in_dm_rdata;
  logic [XLEN-1:0]   in_alu_out;
  logic              in_mem_to_reg;
  logic              in_wen;
  logic [1:0]        in_ld_size;
  logic              in_ld_unsigned;

  logic              wb_valid;
  logic [XLEN-1:0]   wb_pc;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_wen;
  logic [XLEN-1:0]   wb_data;
  logic              byp_wen;
  logic [REG_AW-1:0] byp_rd;
  logic [XLEN-1:0]   byp_data;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output flushW, bubbleW, in_valid, in_pc, in_rd, in_dm_rdata, in_alu_out,
           in_mem_to_reg, in_wen, in_ld_size, in_ld_unsigned,
    input  wb_valid, wb_pc, wb_rd, wb_wen, wb_data, byp_wen, byp_rd, byp_data, retire_cnt
  );

  modport slave (
    input  flushW, bubbleW, in_valid, in_pc, in_rd, in_dm_rdata, in_alu_out,
           in_mem_to_reg, in_wen, in_ld_size, in_ld_unsigned,
    output wb_valid, wb_pc, wb_rd, wb_wen, wb_data, byp_wen, byp_rd, byp_data, retire_cnt
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM->WB register with stall/flush, load alignment/extension,
// one-deep register-file bypass and retired-instruction counter.
module wb_stage_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
) (
  input logic            clk,
  input logic            rst,
  wb_stage_pipe_if.slave bus
);

  logic              s_valid;
  logic [XLEN-1:0]   s_pc;
  logic [REG_AW-1:0] s_rd;
  logic [XLEN-1:0]   s_dm_rdata;
  logic [XLEN-1:0]   s_alu_out;
  logic              s_mem_to_reg;
  logic              s_wen;
  logic [1:0]        s_ld_size;
  logic              s_ld_unsigned;
  logic              s_fresh;

  logic              byp_wen_q;
  logic [REG_AW-1:0] byp_rd_q;
  logic [XLEN-1:0]   byp_data_q;
  logic [CNT_W-1:0]  retire_cnt_q;

  logic [31:0]       ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   aligned;
  logic [XLEN-1:0]   wb_data_c;
  logic              wb_wen_c;

  // Stage register; fresh marks an entry on its first cycle in the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid       <= 1'b0;
      s_pc          <= '0;
      s_rd          <= '0;
      s_dm_rdata    <= '0;
      s_alu_out     <= '0;
      s_mem_to_reg  <= 1'b0;
      s_wen         <= 1'b0;
      s_ld_size     <= 2'd0;
      s_ld_unsigned <= 1'b0;
      s_fresh       <= 1'b0;
    end else if (bus.flushW) begin
      s_valid <= 1'b0;
      s_fresh <= 1'b0;
    end else if (bus.bubbleW) begin
      s_fresh <= 1'b0;
    end else begin
      s_valid       <= bus.in_valid;
      s_pc          <= bus.in_pc;
      s_rd          <= bus.in_rd;
      s_dm_rdata    <= bus.in_dm_rdata;
      s_alu_out     <= bus.in_alu_out;
      s_mem_to_reg  <= bus.in_mem_to_reg;
      s_wen         <= bus.in_wen;
      s_ld_size     <= bus.in_ld_size;
      s_ld_unsigned <= bus.in_ld_unsigned;
      s_fresh       <= bus.in_valid;
    end
  end

  // Load alignment; misaligned halfword ignores offset bit 0.
  always_comb begin
    ld_word = s_dm_rdata[31:0];
    ld_byte = ld_word[7:0];
    case (s_alu_out[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = s_alu_out[1] ? ld_word[31:16] : ld_word[15:0];
    case (s_ld_size)
      2'd0:    aligned = s_ld_unsigned ? XLEN'(ld_byte) : XLEN'($signed(ld_byte));
      2'd1:    aligned = s_ld_unsigned ? XLEN'(ld_half) : XLEN'($signed(ld_half));
      default: aligned = s_ld_unsigned ? XLEN'(ld_word) : XLEN'($signed(ld_word));
    endcase
    wb_data_c = s_mem_to_reg ? aligned : s_alu_out;
    wb_wen_c  = s_valid & s_wen & (s_rd != '0);
  end

  // Bypass only re-arms for a fresh entry; retire counts each entry once.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_wen_q    <= 1'b0;
      byp_rd_q     <= '0;
      byp_data_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      byp_wen_q  <= wb_wen_c & s_fresh;
      byp_rd_q   <= s_rd;
      byp_data_q <= wb_data_c;
      if (s_valid && s_fresh) begin
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.wb_valid   = s_valid;
  assign bus.wb_pc      = s_pc;
  assign bus.wb_rd      = s_rd;
  assign bus.wb_wen     = wb_wen_c;
  assign bus.wb_data    = wb_data_c;
  assign bus.byp_wen    = byp_wen_q;
  assign bus.byp_rd     = byp_rd_q;
  assign bus.byp_data   = byp_data_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: expected outputs queued at drive time, popped after each edge.
module tb_wb_stage_pipe;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  typedef struct {
    logic        valid;
    logic        wen;
    logic        known;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        bwen;
    logic        bknown;
    logic [4:0]  brd;
    logic [31:0] bdata;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference model of the stage contents
  logic        m_valid, m_wen, m_fresh, m_known;
  logic [31:0] m_pc, m_data;
  logic [4:0]  m_rd;
  logic        m_bwen, m_bknown;
  logic [4:0]  m_brd;
  logic [31:0] m_bdata;
  logic [3:0]  m_cnt;

  wb_stage_pipe_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  wb_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_data(input logic [31:0] dm, input logic [31:0] alu,
                                           input logic m2r, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int          sh;
    if (!m2r) return alu;
    if (sz == 2'd0) begin
      sh = 8 * int'(alu[1:0]);
      v  = (dm >> sh) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = alu[1] ? 16 : 0;
      v  = (dm >> sh) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = dm;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic v,
                      input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] dm,
                      input logic [31:0] alu, input logic m2r, input logic wen,
                      input logic [1:0] sz, input logic uns);
    exp_t e;
    exp_t got;
    logic cur_wen;
    rst                = r;
    bus.flushW         = f;
    bus.bubbleW        = b;
    bus.in_valid       = v;
    bus.in_pc          = pc;
    bus.in_rd          = rd;
    bus.in_dm_rdata    = dm;
    bus.in_alu_out     = alu;
    bus.in_mem_to_reg  = m2r;
    bus.in_wen         = wen;
    bus.in_ld_size     = sz;
    bus.in_ld_unsigned = uns;

    cur_wen = m_valid & m_wen & (m_rd != 5'd0);
    if (r) begin
      {m_valid, m_wen, m_fresh} = '0;
      m_pc = '0; m_rd = '0; m_data = '0; m_known = 1'b1;
      m_bwen = 1'b0; m_brd = '0; m_bdata = '0; m_bknown = 1'b1; m_cnt = '0;
    end else begin
      m_bwen   = cur_wen & m_fresh;
      m_brd    = m_rd;
      m_bdata  = m_data;
      m_bknown = m_known;
      if (m_valid && m_fresh) m_cnt = m_cnt + 4'd1;
      if (f) begin
        m_valid = 1'b0; m_fresh = 1'b0; m_known = 1'b0;
      end else if (b) begin
        m_fresh = 1'b0;
      end else begin
        m_valid = v; m_fresh = v; m_pc = pc; m_rd = rd; m_wen = wen;
        m_data  = ref_data(dm, alu, m2r, sz, uns);
        m_known = 1'b1;
      end
    end
    e.valid  = m_valid;
    e.wen    = m_valid & m_wen & (m_rd != 5'd0);
    e.known  = m_known;
    e.pc     = m_pc;
    e.rd     = m_rd;
    e.data   = m_data;
    e.bwen   = m_bwen;
    e.bknown = m_bknown;
    e.brd    = m_brd;
    e.bdata  = m_bdata;
    e.cnt    = m_cnt;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk("wb_valid", 32'(bus.wb_valid), 32'(got.valid));
      chk("wb_wen", 32'(bus.wb_wen), 32'(got.wen));
      chk("byp_wen", 32'(bus.byp_wen), 32'(got.bwen));
      chk("retire_cnt", 32'(bus.retire_cnt), 32'(got.cnt));
      if (got.known) begin
        chk("wb_pc", bus.wb_pc, got.pc);
        chk("wb_rd", 32'(bus.wb_rd), 32'(got.rd));
        chk("wb_data", bus.wb_data, got.data);
      end
      if (got.bknown) begin
        chk("byp_rd", 32'(bus.byp_rd), 32'(got.brd));
        chk("byp_data", bus.byp_data, got.bdata);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    {m_valid, m_wen, m_fresh, m_known, m_bwen, m_bknown} = '0;
    m_pc = '0; m_rd = '0; m_data = '0; m_brd = '0; m_bdata = '0; m_cnt = '0;

    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 5'd3, 32'h55, 32'h66, 1'b0, 1'b1, 2'd0, 1'b0);

    // ALU writeback, then bypass and retire one edge later
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 5'd5, 32'h0, 32'h1234, 1'b0, 1'b1, 2'd2, 1'b0);
    idle();

    // Load alignment and extension
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 5'd6, 32'h80FF7F01, 32'h2, 1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h108, 5'd7, 32'h80FF7F01, 32'h2, 1'b1, 1'b1, 2'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C, 5'd8, 32'h80FF7F01, 32'h2, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 5'd9, 32'h80FF7F01, 32'h3, 1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h114, 5'd10, 32'h80FF7F01, 32'h1, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h118, 5'd11, 32'h80FF7F01, 32'h0, 1'b1, 1'b1, 2'd3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h11C, 5'd12, 32'h80FF7F01, 32'h2, 1'b1, 1'b1, 2'd1, 1'b1);

    // Three-cycle bubble: contents hold, single retire, single bypass pulse
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 5'd13, 32'h0, 32'hCAFE, 1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD, 5'd31, 32'hFFFF, 32'hBEEF, 1'b1, 1'b1, 2'd0, 1'b0);
    end
    idle();
    idle();

    // Flush and bubble together on a valid entry
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 5'd14, 32'h0, 32'h77, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h304, 5'd15, 32'h0, 32'h88, 1'b0, 1'b1, 2'd2, 1'b0);
    idle();

    // rd = 0 write request: gated but still retired
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 5'd0, 32'h0, 32'h99, 1'b0, 1'b1, 2'd2, 1'b0);
    idle();

    // Back-to-back retirements wrap the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h500 + 32'(4 * i), 5'(i + 1), 32'h0, 32'(i), 1'b0, 1'b1, 2'd2, 1'b0);
    end
    idle();

    // Reset during a stall, then normal capture
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h600, 5'd20, 32'h0, 32'hAB, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h604, 5'd21, 32'h0, 32'hCD, 1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h608, 5'd22, 32'h0, 32'hEF, 1'b0, 1'b1, 2'd2, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised writeback stage for the pipelined CPU: a single MEM→WB pipeline register with stall (bubble) hold, flush, load-data alignment and sign/zero extension, a one-deep last-writeback bypass for the register file, and a retired-instruction counter. It sits between the MEM stage and the register file and feeds the hazard/forwarding unit.

## Interface
Parameters:
- XLEN, 32: datapath / PC width (32 or 64).
- REG_AW, 5: register address width.
- CNT_W, 64: retire counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flushW  in  1  invalidate the stage at this edge.
- bubbleW  in  1  hold the current stage contents at this edge.
- in_valid  in  1  MEM-stage entry valid.
- in_pc  in  XLEN  PC of the entry.
- in_rd  in  REG_AW  destination register.
- in_dm_rdata  in  XLEN  raw data-memory word.
- in_alu_out  in  XLEN  ALU result; low 2 bits also give the load byte offset.
- in_mem_to_reg  in  1  1 selects the aligned load data, 0 selects in_alu_out.
- in_wen  in  1  register write request.
- in_ld_size  in  2  0 byte, 1 half, 2 word, 3 word.
- in_ld_unsigned  in  1  zero-extend the load instead of sign-extending.
- wb_valid  out  1  stage holds a valid entry.
- wb_pc  out  XLEN  PC of the entry.
- wb_rd  out  REG_AW  write address.
- wb_wen  out  1  wb_valid & wen & (rd != 0).
- wb_data  out  XLEN  writeback value.
- byp_wen, byp_rd, byp_data  out  1/REG_AW/XLEN  previous cycle's committed write.
- retire_cnt  out  CNT_W  count of retired entries.

## Operation
- Stage register fields: valid, pc, rd, dm_rdata, alu_out, mem_to_reg, wen, ld_size, ld_unsigned, fresh.
- Edge priority: rst > flushW > bubbleW > capture.
  - rst: all fields, bypass registers and retire_cnt go to 0.
  - flushW: valid and fresh go to 0. Other fields are don't-care, but outputs stay gated.
  - bubbleW (no flush): all fields hold and fresh goes to 0.
  - Capture: all fields load from the inputs and fresh = in_valid.
- Load alignment uses offset = alu_out[1:0]:
  - byte: dm_rdata[8*offset +: 8].
  - half: dm_rdata[16*offset[1] +: 16]. offset[0] is ignored; misalignment is not trapped here.
  - word: dm_rdata[31:0]. When XLEN = 64, sign- or zero-extended per ld_unsigned.
  - Extension fills to XLEN using bit 7, 15 or 31 unless ld_unsigned.
- wb_data = mem_to_reg ? aligned : alu_out.
- All outputs are combinational from the stage register. wb_rd, wb_pc and wb_data are driven even when invalid; wb_wen is gated.
- Bypass: each edge (not rst), byp_wen <= wb_wen & fresh, byp_rd <= wb_rd, byp_data <= wb_data. A held (bubbled) entry does not re-arm the bypass.
- Retire: at each edge, if valid & fresh then retire_cnt <= retire_cnt + 1, wrapping modulo 2^CNT_W. This evaluates the entry present before the edge, so each entry counts once regardless of how long it is held. A flush arriving in the same cycle does not cancel that increment.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the wb_* outputs after edge N.
- Bypass outputs lag wb_* by exactly 1 cycle.
- Reset values: wb_valid 0, wb_wen 0, wb_pc 0, wb_rd 0, wb_data 0, byp_* 0, retire_cnt 0.
- flushW and bubbleW asserted together: flush wins and the stage becomes empty.
- bubbleW held for k cycles: outputs are constant for k+1 cycles, wb_wen stays asserted throughout (idempotent rewrite), and retire_cnt increments once.
- rd = 0 with wen = 1: wb_wen = 0, byp_wen = 0, and the entry is still retired.
- rst asserted mid-stall: cleared at the next edge, and the following non-reset edge captures normally.
- retire_cnt at all-ones with a retiring entry wraps to 0.

## Test plan
- Reset, then capture valid=1, rd=5, alu_out=0x1234, mem_to_reg=0, wen=1 → next cycle wb_wen=1, wb_rd=5, wb_data=0x1234; one further edge later retire_cnt=1, byp_wen=1, byp_rd=5.
- dm_rdata=0x80FF7F01, alu_out=0x...2, ld_size=0, signed → wb_data=0xFFFFFFFF. Same with ld_unsigned=1 → 0x000000FF. ld_size=1 with offset 2 → 0xFFFF80FF.
- bubbleW asserted for 3 cycles with an entry in the stage → outputs are unchanged for 4 cycles, retire_cnt +1 total, byp_wen pulses once.
- flushW and bubbleW asserted together on a valid entry → wb_valid=0 and wb_wen=0 next cycle; retire_cnt still +1 for the entry already present.
- Capture wen=1, rd=0 → wb_wen=0, retire_cnt +1. Preload retire_cnt to all-ones (via CNT_W=4 build) → wraps to 0.
- Assert rst during a stall → all outputs 0 at the next edge, and a new valid entry is captured on the following edge.
